// File: rtl/i2s_axis_packer_if.sv
// AXI4-Stream bundle carrying packed sample words from the packer toward the DMA.
interface i2s_axis_packer_if #(
    parameter int DATA_W = 32
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/i2s_axis_packer.sv
// Packs 16-bit I2S samples into 32-bit words, buffers them and streams fixed-length
// AXIS packets; drops and counts words instead of stalling when storage is full.
module i2s_axis_packer #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH         = 16,
    parameter int FIFO_DEPTH           = 512,
    parameter int PACKET_BEATS         = 256
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wen,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   wdata,
    input  logic                              flush,
    i2s_axis_packer_if.master                 m_axis,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              overflow,
    output logic [15:0]                       drop_count
);
    localparam int W      = C_M_AXIS_TDATA_WIDTH;
    localparam int S      = SAMPLE_WIDTH;
    localparam int KW     = W / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(PACKET_BEATS);

    localparam logic [KW-1:0] KEEP_FULL = '1;
    localparam logic [KW-1:0] KEEP_HALF = {{(KW/2){1'b0}}, {(KW/2){1'b1}}};

    typedef struct packed {
        logic         last;
        logic         half;
        logic [W-1:0] data;
    } entry_t;

    logic               pack_phase, phase_nxt;
    logic [S-1:0]       pending, pending_nxt;
    logic               push_req, push_ok, pop;
    entry_t             push_word, head;

    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               just_pushed;

    logic               tvalid_q, last_q;
    logic [W-1:0]       tdata_q;
    logic [KW-1:0]      tkeep_q;
    logic [BEAT_W-1:0]  beat_cnt;

    logic               unused_hi;
    assign unused_hi = ^wdata[W-1:S];

    // wen is folded in first so a flush in the same cycle sees the updated pending state
    always_comb begin
        push_req    = 1'b0;
        push_word   = '0;
        phase_nxt   = pack_phase;
        pending_nxt = pending;
        if (wen) begin
            if (pack_phase) begin
                push_req       = 1'b1;
                push_word.data = {wdata[S-1:0], pending};
                phase_nxt      = 1'b0;
            end else begin
                pending_nxt = wdata[S-1:0];
                phase_nxt   = 1'b1;
            end
        end
        if (flush && phase_nxt) begin
            push_req       = 1'b1;
            push_word.last = 1'b1;
            push_word.half = 1'b1;
            push_word.data = {{(W-S){1'b0}}, pending_nxt};
            phase_nxt      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pack_phase <= 1'b0;
            pending    <= '0;
        end else begin
            pack_phase <= phase_nxt;
            pending    <= pending_nxt;
        end
    end

    // An entry written this cycle is readable from the next one, like a registered-write RAM;
    // that gives the two-edge push-to-tvalid latency.
    assign head    = mem[rd_ptr];
    assign pop     = (fifo_level > LVL_W'(just_pushed)) && (!tvalid_q || m_axis.tready);
    assign push_ok = push_req && ((fifo_level < LVL_W'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            just_pushed <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            just_pushed <= push_ok;
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            last_q   <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (pop) begin
                tvalid_q <= 1'b1;
                tdata_q  <= head.data;
                tkeep_q  <= head.half ? KEEP_HALF : KEEP_FULL;
                last_q   <= head.last;
            end else if (tvalid_q && m_axis.tready) begin
                tvalid_q <= 1'b0;
            end
            if (tvalid_q && m_axis.tready)
                beat_cnt <= m_axis.tlast ? '0 : beat_cnt + BEAT_W'(1);
        end
    end

    // beat_cnt only moves on an accepted beat, so tlast stays stable across a stall
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tlast  = tvalid_q && (last_q || (beat_cnt == BEAT_W'(PACKET_BEATS - 1)));

endmodule

// File: tb/tb_i2s_axis_packer.sv
// Scoreboard bench for i2s_axis_packer: small depth and packet length to reach the edges quickly.
module tb_i2s_axis_packer;
    localparam int W  = 32;
    localparam int PB = 4;

    logic          clk = 1'b0;
    logic          rst_n, wen, flush;
    logic [W-1:0]  wdata;
    logic [2:0]    fifo_level;
    logic          overflow;
    logic [15:0]   drop_count;

    i2s_axis_packer_if #(.DATA_W(W)) axis ();

    i2s_axis_packer #(
        .C_M_AXIS_TDATA_WIDTH(W), .SAMPLE_WIDTH(16), .FIFO_DEPTH(4), .PACKET_BEATS(PB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wdata), .flush(flush),
        .m_axis(axis), .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, beats_seen = 0;
    logic [36:0] q[$];
    logic        m_phase = 1'b0;
    logic [15:0] m_pend = '0;
    int          m_beat = 0, word_idx = 0, drop_lo = 0, drop_hi = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic emit(input logic [31:0] d, input logic [3:0] k, input logic e);
        logic l;
        word_idx++;
        if (word_idx >= drop_lo && word_idx <= drop_hi) return;
        l = e || (m_beat == PB - 1);
        q.push_back({l, k, d});
        m_beat = l ? 0 : m_beat + 1;
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic f);
        wen   = w;
        wdata = {16'($urandom), d};
        flush = f;
        tick();
        wen   = 1'b0;
        flush = 1'b0;
        if (w) begin
            if (m_phase) begin
                emit({d, m_pend}, 4'hF, 1'b0);
                m_phase = 1'b0;
            end else begin
                m_pend  = d;
                m_phase = 1'b1;
            end
        end
        if (f && m_phase) begin
            emit({16'h0, m_pend}, 4'h3, 1'b1);
            m_phase = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q.delete();
        m_phase  = 1'b0;
        m_beat   = 0;
        word_idx = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0 && !axis.tvalid) break;
            tick();
        end
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && axis.tvalid && axis.tready) begin
            beats_seen++;
            if (q.size() == 0) chk("extra_beat", {axis.tlast, axis.tkeep, axis.tdata}, 64'd0);
            else chk("beat", {axis.tlast, axis.tkeep, axis.tdata}, q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int b0;
        rst_n = 1'b0; wen = 1'b0; flush = 1'b0; wdata = '0; axis.tready = 1'b1;
        tick(); tick();
        chk("rst_tvalid", 64'(axis.tvalid), 0);
        chk("rst_tdata",  64'(axis.tdata), 0);
        chk("rst_tkeep",  64'(axis.tkeep), 0);
        chk("rst_tlast",  64'(axis.tlast), 0);
        chk("rst_level",  64'(fifo_level), 0);
        chk("rst_ovf",    64'(overflow), 0);
        chk("rst_drops",  64'(drop_count), 0);
        rst_n = 1'b1;

        // basic pairing and push-to-tvalid latency
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 16'(i), 1'b0);
            if (i == 2 || i == 3) chk("lat_early", 64'(axis.tvalid), 0);
            if (i == 4)           chk("lat_due", 64'(axis.tvalid), 1);
        end
        drain();

        // packet boundaries
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
        drain();

        // flush: odd sample count, then a fresh packet, an idle flush, and wen+flush overlaps
        step(1'b1, 16'hAAAA, 1'b0);
        step(1'b1, 16'hBBBB, 1'b0);
        step(1'b1, 16'hCCCC, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        drain();
        for (int i = 1; i <= 8; i++) step(1'b1, 16'h1100 + 16'(i), 1'b0);
        drain();
        step(1'b0, 16'h0, 1'b1);
        tick(); tick(); tick();
        chk("idle_flush_lvl", 64'(fifo_level), 0);
        chk("idle_flush_vld", 64'(axis.tvalid), 0);
        step(1'b1, 16'hD00D, 1'b1);
        step(1'b1, 16'hE00E, 1'b0);
        step(1'b1, 16'hF00F, 1'b1);
        drain();

        // overflow with the sink stalled
        do_reset();
        drop_lo = 6; drop_hi = 7;
        axis.tready = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            step(1'b1, 16'h0200 + 16'(i), 1'b0);
            if (i == 10) chk("ovf_before", 64'(overflow), 0);
            if (i == 12) begin
                chk("ovf_rise", 64'(overflow), 1);
                chk("drops_1", 64'(drop_count), 1);
            end
        end
        chk("full_level", 64'(fifo_level), 4);
        chk("drops_2", 64'(drop_count), 2);
        tick(); tick();
        chk("stall_vld", 64'(axis.tvalid), 1);
        chk("stall_data", 64'(axis.tdata), 64'h0202_0201);
        drop_lo = 0; drop_hi = -1;
        b0 = beats_seen;
        axis.tready = 1'b1;
        drain();
        chk("ovf_nout", 64'(beats_seen - b0), 5);

        // full FIFO, pop and push on the same edge
        axis.tready = 1'b0;
        for (int i = 1; i <= 11; i++) step(1'b1, 16'h0300 + 16'(i), 1'b0);
        chk("refill_level", 64'(fifo_level), 4);
        b0 = beats_seen;
        axis.tready = 1'b1;
        step(1'b1, 16'h030C, 1'b0);
        chk("pp_level", 64'(fifo_level), 4);
        chk("pp_drops", 64'(drop_count), 2);
        drain();
        chk("pp_nout", 64'(beats_seen - b0), 6);

        // reset mid-packet with buffered words and a pending half
        axis.tready = 1'b0;
        for (int i = 1; i <= 9; i++) step(1'b1, 16'h0400 + 16'(i), 1'b0);
        chk("pre_rst_level", 64'(fifo_level), 3);
        do_reset();
        chk("mid_rst_vld", 64'(axis.tvalid), 0);
        chk("mid_rst_lvl", 64'(fifo_level), 0);
        chk("mid_rst_ovf", 64'(overflow), 0);
        axis.tready = 1'b1;
        step(1'b1, 16'h00A1, 1'b0);
        step(1'b1, 16'h00A2, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
